// File: rtl/ram_bus_master.sv
// Bus master for the shared-bus RAM: turns a valid/ready request into an
// address phase plus data phase on the tristate bus and returns a one-cycle response.
module ram_bus_master #(
    parameter int BITW       = 8,
    parameter int RD_LATENCY = 2,
    parameter int TURNAROUND = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [BITW-1:0] req_addr,
    input  logic [BITW-1:0] req_wdata,
    output logic            rsp_valid,
    output logic            rsp_write,
    output logic [BITW-1:0] rsp_rdata,
    output logic            ram_enable,
    output logic            ram_rw,
    inout  wire  [BITW-1:0] bus
);

    localparam int CNT_MAX = (RD_LATENCY > TURNAROUND) ? RD_LATENCY : TURNAROUND;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_RWAIT, S_RESP, S_TURN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BITW-1:0]   addr_q, addr_d;
    logic [BITW-1:0]   wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [BITW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_write_q, rsp_write_d;
    logic              bus_oe;
    logic [BITW-1:0]   bus_out;

    assign bus       = bus_oe ? bus_out : {BITW{1'bz}};
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_write = rsp_write_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_write_d = rsp_write_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        ram_enable  = 1'b0;
        ram_rw      = 1'b0;
        bus_oe      = 1'b0;
        bus_out     = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = !reset;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                ram_enable = 1'b1;
                ram_rw     = write_q;
                bus_oe     = 1'b1;
                bus_out    = addr_q;
                if (write_q) begin
                    state_d = S_WDATA;
                end else begin
                    state_d = S_RWAIT;
                    cnt_d   = RD_LOAD;
                end
            end
            S_WDATA: begin
                ram_enable  = 1'b1;
                ram_rw      = 1'b1;
                bus_oe      = 1'b1;
                bus_out     = wdata_q;
                rsp_rdata_d = '0;
                rsp_write_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RWAIT: begin
                // Only the first wait cycle is the RAM's read data phase.
                ram_enable = (cnt_q == RD_LOAD);
                if (cnt_q == '0) begin
                    rsp_rdata_d = bus;
                    rsp_write_d = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (!write_q && (TURNAROUND > 0)) begin
                    state_d = S_TURN;
                    cnt_d   = TURN_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
